key_event_conditioner: RTL and testbench
========================================

// Module: key_event_conditioner
// PURPOSE
//  Input-side counterpart of the clock/calendar display manager. Turns raw active-low push-buttons
//  (Edit, Plus, Minus, Swi) into clean, one-cycle event pulses.
//  Per key: 2-flop synchronizer, counter debounce, press/release pulses and optional hold-to-repeat
//  (so Plus/Minus can slew minutes/years). Outputs feed the key/screen/mode managers directly.
// PARAMETERS
//  NUM_KEYS        4         number of independent keys; bit 0=Edit, 1=Plus, 2=Minus, 3=Swi
//  DEBOUNCE_CYCLES 500000    consecutive stable samples needed to accept a level change (10 ms @ 50 MHz)
//  REPEAT_DELAY    25000000  held cycles after key_press before the first key_repeat (0.5 s)
//  REPEAT_RATE     5000000   cycles between successive key_repeat pulses (0.1 s)
//  CNT_W           25        timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  key_n       in   NUM_KEYS  raw asynchronous buttons, 0 = pressed
//  repeat_en   in   NUM_KEYS  per-key auto-repeat enable (sampled every cycle)
//  key_level   out  NUM_KEYS  debounced pressed level, 1 = pressed
//  key_press   out  NUM_KEYS  1-cycle pulse on accepted press
//  key_release out  NUM_KEYS  1-cycle pulse on accepted release
//  key_repeat  out  NUM_KEYS  1-cycle pulse per auto-repeat tick
//  key_event   out  NUM_KEYS  key_press | key_repeat, same cycle (single "act" strobe for consumers)
// BEHAVIOUR
//  - Reset: all outputs 0; synchronizer flops 1 (released); every FSM IDLE; timers 0.
//    A key held through reset is treated as a new press: key_press fires 2+DEBOUNCE_CYCLES cycles
//    after reset deasserts.
//  - Keys are fully independent: one FSM and one CNT_W timer per key. Simultaneous events on
//    different keys all pulse in the same cycle.
//  - p = synchronized pressed (~sync2). All outputs are registered.
//  - Per-key FSM:
//    - IDLE: p=1 -> PRESS_WAIT, timer=1.
//    - PRESS_WAIT: p=0 -> IDLE, timer=0, no pulse (glitch rejected). p=1 and timer==DEBOUNCE_CYCLES-1
//      -> HELD, timer=0, key_press=1, key_level=1. Otherwise timer++.
//    - HELD: p=0 -> RELEASE_WAIT, timer=1. p=1, repeat_en=1 and timer==REPEAT_DELAY-1 -> REPEAT,
//      timer=0, key_repeat=1. Otherwise timer++ (saturates at REPEAT_DELAY-1 while repeat_en=0).
//    - REPEAT: p=0 -> RELEASE_WAIT, timer=1. timer==REPEAT_RATE-1 -> timer=0, key_repeat=repeat_en.
//      Otherwise timer++. Deasserting repeat_en suppresses pulses but stays in REPEAT until release.
//    - RELEASE_WAIT: p=1 -> HELD, timer=0, no new key_press (bounce on release).
//      p=0 and timer==DEBOUNCE_CYCLES-1 -> IDLE, key_release=1, key_level=0. Otherwise timer++.
//  - key_level=1 in HELD/REPEAT/RELEASE_WAIT, including the key_press cycle; 0 from the
//    key_release cycle on.
//  - Latency: edge 0 = first clk edge sampling the new key_n level. The pulse is visible after
//    edge 1+DEBOUNCE_CYCLES (2 synchronizer + DEBOUNCE_CYCLES-1 counting edges).
//  - Pulses are exactly one cycle wide.
//  - key_press, key_repeat and key_release are mutually exclusive per key per cycle.
//  - Reset mid-operation (any state): return to reset values immediately; no key_release is emitted.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_KEYS=4)
//  1. key_n[1] 1->0 at edge 0, held -> key_press[1]=key_event[1]=1 for the one cycle after
//     edge 5; key_level[1]=1 from then on.
//  2. key_n[0] low for 3 cycles, then high -> no key_press/key_level on bit 0 ever; FSM back
//     in IDLE.
//  3. key_n[2] held, repeat_en[2]=1 -> key_press, key_repeat 10 cycles later, then every 3
//     cycles. Release -> key_release 6 cycles after key_n rises; no further repeats.
//  4. Same as 3 with repeat_en[2]=0 -> exactly one key_press, zero key_repeat, one key_release.
//  5. Held key bounces high for 2 cycles, then low -> key_level stays 1; no key_release; no
//     second key_press.
//  6. key_n[1], key_n[3] pressed on the same edge; reset asserted while both HELD ->
//     - simultaneous key_press on both bits;
//     - after reset all outputs 0 next cycle, no key_release;
//     - still held, so both re-press 6 cycles after reset drops.

Source files
------------

// File: rtl/key_event_conditioner_if.sv
// Key interface: raw buttons and repeat enables in, conditioned levels and event strobes out.
interface key_event_conditioner_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] repeat_en;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_event;

    modport master (
        output key_n, repeat_en,
        input  key_level, key_press, key_release, key_repeat, key_event
    );

    modport slave (
        input  key_n, repeat_en,
        output key_level, key_press, key_release, key_repeat, key_event
    );
endinterface

// File: rtl/key_event_conditioner.sv
// Per-key synchronizer, debounce FSM and hold-to-repeat generator producing one-cycle
// press/release/repeat strobes from active-low push-buttons.
module key_event_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input logic                    clk,
    input logic                    reset,
    key_event_conditioner_if.slave kif
);
    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [NUM_KEYS-1:0] event_q, event_d;
    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    timer_q [NUM_KEYS];
    logic [CNT_W-1:0]    timer_d [NUM_KEYS];
    logic                p;

    always_comb begin
        sync1_d   = kif.key_n;
        sync2_d   = sync1_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        level_d   = '0;
        p         = 1'b0;
        state_d   = state_q;
        timer_d   = timer_q;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            p = ~sync2_q[k];
            unique case (state_q[k])
                IDLE: begin
                    if (p) begin
                        state_d[k] = PRESS_WAIT;
                        timer_d[k] = TIMER_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state_d[k] = IDLE;
                        timer_d[k] = '0;
                    end else if (timer_q[k] == DB_LAST) begin
                        state_d[k] = HELD;
                        timer_d[k] = '0;
                        press_d[k] = 1'b1;
                    end else begin
                        timer_d[k] = timer_q[k] + TIMER_ONE;
                    end
                end
                HELD: begin
                    // Timer parks at the delay limit while repeat is disabled, so
                    // enabling repeat later fires on the very next held cycle.
                    if (!p) begin
                        state_d[k] = RELEASE_WAIT;
                        timer_d[k] = TIMER_ONE;
                    end else if (timer_q[k] == DELAY_LAST) begin
                        if (kif.repeat_en[k]) begin
                            state_d[k]  = REPEAT;
                            timer_d[k]  = '0;
                            repeat_d[k] = 1'b1;
                        end
                    end else begin
                        timer_d[k] = timer_q[k] + TIMER_ONE;
                    end
                end
                REPEAT: begin
                    if (!p) begin
                        state_d[k] = RELEASE_WAIT;
                        timer_d[k] = TIMER_ONE;
                    end else if (timer_q[k] == RATE_LAST) begin
                        timer_d[k]  = '0;
                        repeat_d[k] = kif.repeat_en[k];
                    end else begin
                        timer_d[k] = timer_q[k] + TIMER_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state_d[k] = HELD;
                        timer_d[k] = '0;
                    end else if (timer_q[k] == DB_LAST) begin
                        state_d[k]   = IDLE;
                        timer_d[k]   = '0;
                        release_d[k] = 1'b1;
                    end else begin
                        timer_d[k] = timer_q[k] + TIMER_ONE;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    timer_d[k] = '0;
                end
            endcase
            level_d[k] = (state_d[k] == HELD) || (state_d[k] == REPEAT) ||
                         (state_d[k] == RELEASE_WAIT);
        end
        event_d = press_d | repeat_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            event_q   <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= IDLE;
                timer_q[k] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            event_q   <= event_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_repeat  = repeat_q;
    assign kif.key_event   = event_q;
endmodule

// File: tb/tb_key_event_conditioner.sv
// Scoreboard bench: expected strobes are queued with their due cycle when keys are driven.
module tb_key_event_conditioner;
    localparam int NK = 4;
    localparam int LAT = 6;  // drive point to visible pulse: 1 + 1 + DEBOUNCE_CYCLES

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   edge_cnt = 0;
    logic rst_seen = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        int cyc;
        int kind;  // 0 press, 1 repeat, 2 release
        int key;
    } exp_t;
    exp_t sb[$];

    logic [NK-1:0] exp_p, exp_rp, exp_rl, lvl_exp;

    key_event_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_event_conditioner #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kif(kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        rst_seen = reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
    endtask

    task automatic expect_ev(input int cyc, input int kind, input int key);
        exp_t e;
        e.cyc = cyc;
        e.kind = kind;
        e.key = key;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            exp_p = '0;
            exp_rp = '0;
            exp_rl = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == edge_cnt) begin
                    case (sb[i].kind)
                        0: exp_p[sb[i].key] = 1'b1;
                        1: exp_rp[sb[i].key] = 1'b1;
                        default: exp_rl[sb[i].key] = 1'b1;
                    endcase
                    sb.delete(i);
                end else if (sb[i].cyc < edge_cnt) begin
                    check_eq("stale_expectation_cycle", sb[i].cyc, edge_cnt);
                    sb.delete(i);
                end
            end
            if (rst_seen) lvl_exp = '0;
            else lvl_exp = (lvl_exp | exp_p) & ~exp_rl;
            check_eq("key_press", kif.key_press, exp_p);
            check_eq("key_repeat", kif.key_repeat, exp_rp);
            check_eq("key_release", kif.key_release, exp_rl);
            check_eq("key_event", kif.key_event, exp_p | exp_rp);
            check_eq("key_level", kif.key_level, lvl_exp);
        end
    end

    initial begin
        int n;
        lvl_exp = '0;
        kif.key_n = '1;
        kif.repeat_en = '0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // basic press / release on Plus
        kif.key_n[1] = 1'b0;
        expect_ev(edge_cnt + LAT, 0, 1);
        tick(12);
        kif.key_n[1] = 1'b1;
        expect_ev(edge_cnt + LAT, 2, 1);
        tick(10);

        // 3-cycle glitch on Edit is rejected
        kif.key_n[0] = 1'b0;
        tick(3);
        kif.key_n[0] = 1'b1;
        tick(10);

        // Minus held with auto-repeat
        kif.repeat_en[2] = 1'b1;
        kif.key_n[2] = 1'b0;
        n = edge_cnt;
        expect_ev(n + LAT, 0, 2);
        for (int c = n + LAT + 10; c <= n + 30 + 2; c += 3) expect_ev(c, 1, 2);
        tick(30);
        kif.key_n[2] = 1'b1;
        expect_ev(edge_cnt + LAT, 2, 2);
        tick(12);
        kif.repeat_en[2] = 1'b0;

        // Minus held without repeat
        kif.key_n[2] = 1'b0;
        expect_ev(edge_cnt + LAT, 0, 2);
        tick(30);
        kif.key_n[2] = 1'b1;
        expect_ev(edge_cnt + LAT, 2, 2);
        tick(12);

        // release bounce on a held key
        kif.key_n[0] = 1'b0;
        expect_ev(edge_cnt + LAT, 0, 0);
        tick(10);
        kif.key_n[0] = 1'b1;
        tick(2);
        kif.key_n[0] = 1'b0;
        tick(10);
        kif.key_n[0] = 1'b1;
        expect_ev(edge_cnt + LAT, 2, 0);
        tick(10);

        // simultaneous press, then reset while both held
        kif.key_n[1] = 1'b0;
        kif.key_n[3] = 1'b0;
        expect_ev(edge_cnt + LAT, 0, 1);
        expect_ev(edge_cnt + LAT, 0, 3);
        tick(8);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_ev(edge_cnt + LAT, 0, 1);
        expect_ev(edge_cnt + LAT, 0, 3);
        tick(10);
        kif.key_n[1] = 1'b1;
        kif.key_n[3] = 1'b1;
        expect_ev(edge_cnt + LAT, 2, 1);
        expect_ev(edge_cnt + LAT, 2, 3);
        tick(10);

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
